// File: rtl/hls_bus_pkg.sv
// Shared definitions for the HLS bus arbiter: command packing, field offsets, FSM encoding.
// Payload is packed {address, data, mask[3:0], write, uncached, size[2:0], last}, LSB first from last.
package hls_bus_pkg;

  localparam int LAST_BIT     = 0;
  localparam int SIZE_LSB     = 1;
  localparam int UNCACHED_BIT = 4;
  localparam int WRITE_BIT    = 5;
  localparam int MASK_LSB     = 6;
  localparam int DATA_LSB     = 10;

  function automatic int cmd_w(input int addr_w, input int data_w);
    return addr_w + data_w + 10;
  endfunction

  // Address sits directly above the data field, so its offset depends on the data width.
  function automatic int addr_lsb(input int data_w);
    return DATA_LSB + data_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/hls_bus_arbiter_id_fifo.sv
// In-order 1-bit ID FIFO recording which master owns each outstanding read.
// Push visible at head next cycle; push ignored when full, pop ignored when empty.
module hls_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/hls_bus_arbiter.sv
// Round-robin 2:1 arbiter onto the HLS cmd/rsp bus with write-burst lock and in-order read ID tracking.
// Grant takes one IDLE cycle, then cmd and rsp paths are combinational; reads stall while the ID FIFO is full.
module hls_bus_arbiter
  import hls_bus_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int ID_FIFO_DEPTH   = 4,
  localparam int CMD_W          = cmd_w(DATA_ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cmd_valid,
  output logic                  m0_cmd_ready,
  input  logic [CMD_W-1:0]      m0_cmd_payload,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_data,
  output logic                  m0_rsp_last,
  input  logic                  m1_cmd_valid,
  output logic                  m1_cmd_ready,
  input  logic [CMD_W-1:0]      m1_cmd_payload,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_data,
  output logic                  m1_rsp_last,
  output logic                  io_bus_cmd_valid,
  input  logic                  io_bus_cmd_ready,
  output logic [CMD_W-1:0]      io_bus_cmd_payload,
  input  logic                  io_bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] io_bus_rsp_payload_data,
  input  logic                  io_bus_rsp_payload_last,
  output logic                  err_orphan_rsp
);

  arb_state_t       state;
  logic             rr;
  logic [CMD_W-1:0] sel_payload;
  logic             own_valid;
  logic             blk;
  logic             fire;
  logic             push;
  logic             pop;
  logic             id_full;
  logic             id_empty;
  logic             id_head;

  assign sel_payload = (state == OWN1) ? m1_cmd_payload : m0_cmd_payload;
  assign own_valid   = ((state == OWN0) & m0_cmd_valid) | ((state == OWN1) & m1_cmd_valid);

  // Reads must not issue without a free ID slot; writes get no response so never stall.
  assign blk = ~sel_payload[WRITE_BIT] & id_full;

  assign io_bus_cmd_valid   = own_valid & ~blk;
  assign io_bus_cmd_payload = sel_payload;
  assign m0_cmd_ready       = (state == OWN0) & io_bus_cmd_ready & ~blk;
  assign m1_cmd_ready       = (state == OWN1) & io_bus_cmd_ready & ~blk;

  assign fire = io_bus_cmd_valid & io_bus_cmd_ready;
  assign push = fire & ~sel_payload[WRITE_BIT] & sel_payload[LAST_BIT];
  assign pop  = io_bus_rsp_valid & io_bus_rsp_payload_last & ~id_empty;

  assign m0_rsp_valid = io_bus_rsp_valid & ~id_empty & ~id_head;
  assign m1_rsp_valid = io_bus_rsp_valid & ~id_empty & id_head;
  assign m0_rsp_data  = io_bus_rsp_payload_data;
  assign m1_rsp_data  = io_bus_rsp_payload_data;
  assign m0_rsp_last  = io_bus_rsp_payload_last;
  assign m1_rsp_last  = io_bus_rsp_payload_last;

  // rr holds the last granted master; on a tie the other one wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cmd_valid && (!m1_cmd_valid || rr)) begin
            state <= OWN0;
            rr    <= 1'b0;
          end else if (m1_cmd_valid) begin
            state <= OWN1;
            rr    <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (fire && sel_payload[LAST_BIT]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_orphan_rsp <= 1'b0;
    end else if (io_bus_rsp_valid && id_empty) begin
      err_orphan_rsp <= 1'b1;
    end
  end

  hls_id_fifo #(
    .DEPTH(ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .push_id(state == OWN1),
    .pop    (pop),
    .full   (id_full),
    .empty  (id_empty),
    .head   (id_head)
  );

endmodule

// File: tb/tb_hls_bus_arbiter.sv
// Directed bench for hls_bus_arbiter: per-cycle vector table plus hand sequences for stall, orphan and reset.
module tb_hls_bus_arbiter;
  import hls_bus_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int CW   = cmd_w(AW, DW);
  localparam int ALSB = addr_lsb(DW);

  logic          clk;
  logic          rst;
  logic          m0_cmd_valid, m0_cmd_ready, m0_rsp_valid, m0_rsp_last;
  logic          m1_cmd_valid, m1_cmd_ready, m1_rsp_valid, m1_rsp_last;
  logic [CW-1:0] m0_cmd_payload, m1_cmd_payload, io_bus_cmd_payload;
  logic [DW-1:0] m0_rsp_data, m1_rsp_data, io_bus_rsp_payload_data;
  logic          io_bus_cmd_valid, io_bus_cmd_ready;
  logic          io_bus_rsp_valid, io_bus_rsp_payload_last;
  logic          err_orphan_rsp;

  int total = 0;
  int bad   = 0;

  hls_bus_arbiter #(
    .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .ID_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_payload(m0_cmd_payload),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_last(m0_rsp_last),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_payload(m1_cmd_payload),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_rsp_last(m1_rsp_last),
    .io_bus_cmd_valid(io_bus_cmd_valid), .io_bus_cmd_ready(io_bus_cmd_ready),
    .io_bus_cmd_payload(io_bus_cmd_payload),
    .io_bus_rsp_valid(io_bus_rsp_valid), .io_bus_rsp_payload_data(io_bus_rsp_payload_data),
    .io_bus_rsp_payload_last(io_bus_rsp_payload_last),
    .err_orphan_rsp(err_orphan_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [CW-1:0] mk(input logic [31:0] a, input logic w, input logic l);
    logic [CW-1:0] p;
    p = '0;
    p[ALSB +: AW]     = a;
    p[DATA_LSB +: DW] = ~a;
    p[MASK_LSB +: 4]  = 4'hF;
    p[WRITE_BIT]      = w;
    p[SIZE_LSB +: 3]  = 3'd2;
    p[LAST_BIT]       = l;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // exp = {io_bus_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid}
  typedef struct {
    logic        m0v, m0w, m0l;
    logic [31:0] m0a;
    logic        m1v, m1w, m1l;
    logic [31:0] m1a;
    logic        ior, rv, rl;
    logic [4:0]  exp;
    logic [31:0] ea;
  } vec_t;

  function automatic vec_t v(input logic m0v, input logic m0w, input logic m0l, input logic [31:0] m0a,
                             input logic m1v, input logic m1w, input logic m1l, input logic [31:0] m1a,
                             input logic ior, input logic rv, input logic rl,
                             input logic [4:0] exp, input logic [31:0] ea);
    vec_t r;
    r.m0v = m0v; r.m0w = m0w; r.m0l = m0l; r.m0a = m0a;
    r.m1v = m1v; r.m1w = m1w; r.m1l = m1l; r.m1a = m1a;
    r.ior = ior; r.rv = rv; r.rl = rl; r.exp = exp; r.ea = ea;
    return r;
  endfunction

  vec_t tbl [25];

  initial begin
    // Tie traffic straight after reset: grants m0,m1,m0,m1, responses route 0,1,0,1.
    tbl[0]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 0,0, 5'b00000, 0);
    tbl[1]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 0,0, 5'b11000, 32'h200);
    tbl[2]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 0,0, 5'b00000, 0);
    tbl[3]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 0,0, 5'b10100, 32'h300);
    tbl[4]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 1,1, 5'b00010, 0);
    tbl[5]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 1,1, 5'b11001, 32'h200);
    tbl[6]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 1,1, 5'b00010, 0);
    tbl[7]  = v(1,0,1,32'h200, 1,0,1,32'h300, 1, 0,0, 5'b10100, 32'h300);
    tbl[8]  = v(0,0,1,32'h200, 0,0,1,32'h300, 1, 1,1, 5'b00001, 0);
    // Single m0 read.
    tbl[9]  = v(1,0,1,32'h100, 0,0,0,0, 1, 0,0, 5'b00000, 0);
    tbl[10] = v(1,0,1,32'h100, 0,0,0,0, 1, 0,0, 5'b11000, 32'h100);
    tbl[11] = v(0,0,1,32'h100, 0,0,0,0, 1, 1,1, 5'b00010, 0);
    tbl[12] = v(0,0,0,0,       0,0,0,0, 1, 0,0, 5'b00000, 0);
    // m1 4-beat write burst with toggling ready while m0 waits.
    tbl[13] = v(1,0,1,32'h400, 1,1,0,32'h500, 1, 0,0, 5'b00000, 0);
    tbl[14] = v(1,0,1,32'h400, 1,1,0,32'h500, 0, 0,0, 5'b10000, 32'h500);
    tbl[15] = v(1,0,1,32'h400, 1,1,0,32'h500, 1, 0,0, 5'b10100, 32'h500);
    tbl[16] = v(1,0,1,32'h400, 1,1,0,32'h504, 0, 0,0, 5'b10000, 32'h504);
    tbl[17] = v(1,0,1,32'h400, 1,1,0,32'h504, 1, 0,0, 5'b10100, 32'h504);
    tbl[18] = v(1,0,1,32'h400, 0,1,0,32'h508, 1, 0,0, 5'b00100, 0);
    tbl[19] = v(1,0,1,32'h400, 1,1,0,32'h508, 1, 0,0, 5'b10100, 32'h508);
    tbl[20] = v(1,0,1,32'h400, 1,1,1,32'h50C, 0, 0,0, 5'b10000, 32'h50C);
    tbl[21] = v(1,0,1,32'h400, 1,1,1,32'h50C, 1, 0,0, 5'b10100, 32'h50C);
    tbl[22] = v(1,0,1,32'h400, 0,0,0,0,       1, 0,0, 5'b00000, 0);
    tbl[23] = v(1,0,1,32'h400, 0,0,0,0,       1, 0,0, 5'b11000, 32'h400);
    tbl[24] = v(0,0,1,32'h400, 0,0,0,0,       1, 1,1, 5'b00010, 0);

    rst = 1'b1;
    m0_cmd_valid = 0; m1_cmd_valid = 0;
    m0_cmd_payload = '0; m1_cmd_payload = '0;
    io_bus_cmd_ready = 0; io_bus_rsp_valid = 0;
    io_bus_rsp_payload_data = 32'hDEADBEEF; io_bus_rsp_payload_last = 0;
    @(negedge clk);
    m0_cmd_valid = 1; m1_cmd_valid = 1; io_bus_cmd_ready = 1;
    #1 chk("reset_outputs", {io_bus_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, err_orphan_rsp}, 6'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      m0_cmd_valid     = tbl[i].m0v;
      m0_cmd_payload   = mk(tbl[i].m0a, tbl[i].m0w, tbl[i].m0l);
      m1_cmd_valid     = tbl[i].m1v;
      m1_cmd_payload   = mk(tbl[i].m1a, tbl[i].m1w, tbl[i].m1l);
      io_bus_cmd_ready = tbl[i].ior;
      io_bus_rsp_valid = tbl[i].rv;
      io_bus_rsp_payload_last = tbl[i].rl;
      #1;
      chk($sformatf("vec%0d_handshake", i),
          {io_bus_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid}, tbl[i].exp);
      if (tbl[i].exp[4])
        chk($sformatf("vec%0d_addr", i), io_bus_cmd_payload[ALSB +: AW], tbl[i].ea);
      if (tbl[i].rv)
        chk($sformatf("vec%0d_rsp_data", i), {m0_rsp_data, m1_rsp_data}, {32'hDEADBEEF, 32'hDEADBEEF});
      @(negedge clk);
    end
    io_bus_rsp_valid = 0; io_bus_rsp_payload_last = 0;

    // Fill the ID FIFO with four m0 reads.
    m0_cmd_valid = 1; m1_cmd_valid = 0; io_bus_cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      m0_cmd_payload = mk(32'h600 + 32'(i * 4), 0, 1);
      #1 chk("fill_idle", io_bus_cmd_valid, 0);
      @(negedge clk);
      #1 chk("fill_issue", {io_bus_cmd_valid, m0_cmd_ready}, 2'b11);
      @(negedge clk);
    end
    m0_cmd_payload = mk(32'h610, 0, 1);
    #1 chk("full_idle", io_bus_cmd_valid, 0);
    @(negedge clk);
    #1 chk("full_read_blocked", {io_bus_cmd_valid, m0_cmd_ready}, 2'b00);
    m0_cmd_payload = mk(32'h700, 1, 1);
    #1 chk("full_write_passes", {io_bus_cmd_valid, m0_cmd_ready}, 2'b11);
    @(negedge clk);
    m0_cmd_payload = mk(32'h610, 0, 1);
    #1 chk("after_write_idle", io_bus_cmd_valid, 0);
    @(negedge clk);
    #1 chk("fifth_read_blocked", {io_bus_cmd_valid, m0_cmd_ready}, 2'b00);
    io_bus_rsp_valid = 1; io_bus_rsp_payload_last = 1;
    #1 chk("free_slot_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b10);
    @(negedge clk);
    io_bus_rsp_valid = 0; io_bus_rsp_payload_last = 0;
    #1 chk("fifth_read_issues", {io_bus_cmd_valid, m0_cmd_ready}, 2'b11);
    chk("fifth_read_payload", io_bus_cmd_payload, mk(32'h610, 0, 1));
    @(negedge clk);
    m0_cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      io_bus_rsp_valid = 1; io_bus_rsp_payload_last = 1;
      #1 chk("drain_rsp", {m0_rsp_valid, m1_rsp_valid}, 2'b10);
      @(negedge clk);
    end
    io_bus_rsp_valid = 0; io_bus_rsp_payload_last = 0;
    #1 chk("no_orphan_yet", err_orphan_rsp, 0);

    // Response with nothing outstanding.
    io_bus_rsp_valid = 1; io_bus_rsp_payload_last = 1;
    #1 chk("orphan_not_routed", {m0_rsp_valid, m1_rsp_valid}, 2'b00);
    @(negedge clk);
    io_bus_rsp_valid = 0; io_bus_rsp_payload_last = 0;
    #1 chk("orphan_flag_set", err_orphan_rsp, 1);
    repeat (3) @(negedge clk);
    #1 chk("orphan_flag_sticky", err_orphan_rsp, 1);

    // Two reads outstanding, then reset in the middle of an m1 write burst.
    m0_cmd_valid = 1;
    for (int i = 0; i < 2; i++) begin
      m0_cmd_payload = mk(32'h800 + 32'(i * 4), 0, 1);
      @(negedge clk);
      #1 chk("pre_reset_read", {io_bus_cmd_valid, m0_cmd_ready}, 2'b11);
      @(negedge clk);
    end
    m0_cmd_valid = 0;
    m1_cmd_valid = 1; m1_cmd_payload = mk(32'hA00, 1, 0);
    @(negedge clk);
    #1 chk("burst_beat1", {io_bus_cmd_valid, m0_cmd_ready, m1_cmd_ready}, 3'b101);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_midburst_outputs", {io_bus_cmd_valid, m0_cmd_ready, m1_cmd_ready}, 3'b000);
    chk("reset_clears_orphan", err_orphan_rsp, 0);
    io_bus_rsp_valid = 1; io_bus_rsp_payload_last = 1;
    #1 chk("reset_fifo_empty", {m0_rsp_valid, m1_rsp_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    io_bus_rsp_valid = 0; io_bus_rsp_payload_last = 0;
    m0_cmd_valid = 1; m0_cmd_payload = mk(32'hB00, 0, 1);
    m1_cmd_valid = 1; m1_cmd_payload = mk(32'hC00, 0, 1);
    #1 chk("post_reset_idle", {io_bus_cmd_valid, m0_cmd_ready, m1_cmd_ready}, 3'b000);
    @(negedge clk);
    #1 chk("post_reset_tie_m0", {io_bus_cmd_valid, m0_cmd_ready, m1_cmd_ready}, 3'b110);
    chk("post_reset_tie_addr", io_bus_cmd_payload[ALSB +: AW], 32'hB00);
    chk("post_reset_no_orphan", err_orphan_rsp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
